// File: rtl/tblink_rpc_invoke_seq.sv
// In-order invoke sequencer: buffers RPC invoke requests, drives one at a time to an RTL BFM
// and returns its result tagged with the call id. Optional macro: TBLINK_RPC_INVOKE_SEQ_TIMEOUT_EN.
module tblink_rpc_invoke_seq #(
  parameter int DEPTH    = 4,
  parameter int METHOD_W = 8,
  parameter int PARAM_W  = 64,
  parameter int RET_W    = 64,
  parameter int TMO_W    = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [63:0]               req_call_id,
  input  logic [METHOD_W-1:0]       req_method,
  input  logic [PARAM_W-1:0]        req_params,
  input  logic                      req_blocking,
  output logic                      bfm_valid,
  input  logic                      bfm_ready,
  output logic [METHOD_W-1:0]       bfm_method,
  output logic [PARAM_W-1:0]        bfm_params,
  input  logic                      bfm_ack,
  input  logic [RET_W-1:0]          bfm_ret,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [63:0]               rsp_call_id,
  output logic [RET_W-1:0]          rsp_ret,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_W < 2) begin : g_param_check
    $error("tblink_rpc_invoke_seq: DEPTH must be a power of two >= 2 and TMO_W >= 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;
  state_t state_reg, state_next;

  logic [63:0]          mem_call_id  [DEPTH];
  logic [METHOD_W-1:0]  mem_method   [DEPTH];
  logic [PARAM_W-1:0]   mem_params   [DEPTH];
  logic                 mem_blocking [DEPTH];

  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic [63:0]          call_id_reg;
  logic [METHOD_W-1:0]  method_reg;
  logic [PARAM_W-1:0]   params_reg;
  logic                 blocking_reg;
  logic [RET_W-1:0]     ret_reg, ret_next;
  logic                 err_reg, err_next;
  logic                 push, pop, load_ret, tmo_hit;

  assign req_ready = reset_n && (count_reg != CW'(DEPTH));
  assign push      = req_valid && req_ready;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    load_ret   = 1'b0;
    ret_next   = '0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bfm_ready) begin
          if (!blocking_reg) begin
            load_ret   = 1'b1;
            state_next = RESP;
          end else if (bfm_ack) begin
            load_ret   = 1'b1;
            ret_next   = bfm_ret;
            state_next = RESP;
          end else begin
            state_next = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (bfm_ack) begin
          load_ret   = 1'b1;
          ret_next   = bfm_ret;
          state_next = RESP;
        end else if (tmo_hit) begin
          load_ret   = 1'b1;
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        // Pop straight into ISSUE on the response handshake so queued calls run back to back.
        if (rsp_ready) begin
          if (count_reg != '0) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage has no reset so it can map onto block RAM; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_call_id[wr_ptr_reg]  <= req_call_id;
      mem_method[wr_ptr_reg]   <= req_method;
      mem_params[wr_ptr_reg]   <= req_params;
      mem_blocking[wr_ptr_reg] <= req_blocking;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      call_id_reg  <= '0;
      method_reg   <= '0;
      params_reg   <= '0;
      blocking_reg <= 1'b0;
      ret_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (pop) begin
        call_id_reg  <= mem_call_id[rd_ptr_reg];
        method_reg   <= mem_method[rd_ptr_reg];
        params_reg   <= mem_params[rd_ptr_reg];
        blocking_reg <= mem_blocking[rd_ptr_reg];
      end
      if (load_ret) begin
        ret_reg <= ret_next;
        err_reg <= err_next;
      end
    end
  end

`ifdef TBLINK_RPC_INVOKE_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_reg;

  // Firing one step before all-ones gives exactly 2**TMO_W-1 cycles in WAIT_ACK.
  assign tmo_hit = (tmo_reg == {{(TMO_W-1){1'b1}}, 1'b0});

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tmo_reg <= '0;
    end else if (state_reg == WAIT_ACK && state_next == WAIT_ACK) begin
      tmo_reg <= tmo_reg + TMO_W'(1);
    end else begin
      tmo_reg <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign bfm_valid   = (state_reg == ISSUE);
  assign bfm_method  = method_reg;
  assign bfm_params  = params_reg;
  assign rsp_valid   = (state_reg == RESP);
  assign rsp_call_id = call_id_reg;
  assign rsp_ret     = ret_reg;
  assign rsp_err     = err_reg;
  assign busy        = (state_reg != IDLE) || (count_reg != '0);
  assign count       = count_reg;

endmodule

// File: tb/tb_tblink_rpc_invoke_seq.sv
// Directed and randomized checks of tblink_rpc_invoke_seq against a queue-based call/response model.
module tb_tblink_rpc_invoke_seq;
  localparam int DEPTH    = 4;
  localparam int METHOD_W = 8;
  localparam int PARAM_W  = 64;
  localparam int RET_W    = 64;
  localparam int TMO_W    = 4;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  req_valid = 1'b0, req_ready, req_blocking = 1'b0;
  logic [63:0]           req_call_id = '0;
  logic [METHOD_W-1:0]   req_method = '0;
  logic [PARAM_W-1:0]    req_params = '0;
  logic                  bfm_valid, bfm_ready = 1'b0, bfm_ack = 1'b0;
  logic [METHOD_W-1:0]   bfm_method;
  logic [PARAM_W-1:0]    bfm_params;
  logic [RET_W-1:0]      bfm_ret = '0;
  logic                  rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [63:0]           rsp_call_id;
  logic [RET_W-1:0]      rsp_ret;
  logic [$clog2(DEPTH):0] count;

  always #5 clock = ~clock;

  tblink_rpc_invoke_seq #(
    .DEPTH(DEPTH), .METHOD_W(METHOD_W), .PARAM_W(PARAM_W), .RET_W(RET_W), .TMO_W(TMO_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_call_id(req_call_id),
    .req_method(req_method), .req_params(req_params), .req_blocking(req_blocking),
    .bfm_valid(bfm_valid), .bfm_ready(bfm_ready), .bfm_method(bfm_method),
    .bfm_params(bfm_params), .bfm_ack(bfm_ack), .bfm_ret(bfm_ret),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_call_id(rsp_call_id),
    .rsp_ret(rsp_ret), .rsp_err(rsp_err), .busy(busy), .count(count)
  );

  typedef struct packed {
    logic [63:0]         id;
    logic [METHOD_W-1:0] m;
    logic [PARAM_W-1:0]  p;
    logic                blk;
  } req_t;
  typedef struct packed {
    logic [63:0]      id;
    logic [RET_W-1:0] ret;
  } rsp_t;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_req(input logic [63:0] id, input logic [7:0] m, input logic [63:0] p,
                          input logic b);
    check("push_ready", req_ready, 1);
    req_call_id = id; req_method = m; req_params = p; req_blocking = b; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    req_t        req_q[$];
    rsp_t        rsp_q[$];
    req_t        wait_req, r;
    logic        waiting, hs_issue;
    int          wait_cyc, n_acc, got, n_push, n_rsp;
    logic [63:0] exp_ids[6];
    logic [63:0] pb;

    // Reset values
    reset_n = 1'b0;
    step(); step();
    check("rst_req_ready", req_ready, 0);
    reset_n = 1'b1;
    step();
    check("rst_bfm_valid", bfm_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_rsp_call_id", rsp_call_id, 0);
    check("rst_rsp_ret", rsp_ret, 0);
    check("rst_bfm_method", bfm_method, 0);
    check("rst_bfm_params", bfm_params, 0);
    check("rst_req_ready_out", req_ready, 1);

    // Single blocking call, ack five cycles after the command handshake
    bfm_ready = 1'b1;
    push_req(64'h11, 8'd3, 64'hAB, 1'b1);
    check("t1_bfm_valid_early", bfm_valid, 0);
    check("t1_count", count, 1);
    step();
    check("t1_bfm_valid", bfm_valid, 1);
    check("t1_bfm_method", bfm_method, 3);
    check("t1_bfm_params", bfm_params, 64'hAB);
    step();
    check("t1_bfm_valid_after_hs", bfm_valid, 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_rsp_wait", rsp_valid, 0);
      step();
    end
    bfm_ack = 1'b1; bfm_ret = 64'h55;
    step();
    bfm_ack = 1'b0;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_call_id", rsp_call_id, 64'h11);
    check("t1_rsp_ret", rsp_ret, 64'h55);
    check("t1_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t1_rsp_done", rsp_valid, 0);
    check("t1_busy_done", busy, 0);

    // Fill the FIFO while the BFM stalls, then drain in order
    bfm_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 20 && n_acc < DEPTH + 1; c++) begin
      req_call_id = 64'h20 + 64'(n_acc); req_method = 8'(n_acc);
      req_params = {$urandom, $urandom}; req_blocking = 1'b0; req_valid = 1'b1;
      if (req_ready) n_acc++;
      step();
    end
    req_valid = 1'b0;
    check("t2_accepted", n_acc, DEPTH + 1);
    check("t2_count_full", count, DEPTH);
    check("t2_req_ready_full", req_ready, 0);
    check("t2_bfm_valid_stalled", bfm_valid, 1);
    req_call_id = 64'h25; req_method = 8'd5; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_held_off", req_ready, 0);
    end
    for (int i = 0; i < 6; i++) exp_ids[i] = 64'h20 + 64'(i);
    bfm_ready = 1'b1; rsp_ready = 1'b1; got = 0;
    for (int c = 0; c < 80 && got < 6; c++) begin
      hs_issue = req_valid && req_ready;
      if (rsp_valid) begin
        check("t2_order_id", rsp_call_id, exp_ids[got]);
        check("t2_ret_zero", rsp_ret, 0);
        got++;
      end
      step();
      if (hs_issue) req_valid = 1'b0;
    end
    check("t2_responses", got, 6);
    bfm_ready = 1'b0; rsp_ready = 1'b0;
    step();
    check("t2_busy_done", busy, 0);

    // Non-blocking call answers right after the command handshake
    bfm_ready = 1'b1; bfm_ret = 64'hDEAD;
    push_req(64'h7, 8'd9, {$urandom, $urandom}, 1'b0);
    step();
    check("t3_bfm_valid", bfm_valid, 1);
    step();
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_rsp_call_id", rsp_call_id, 64'h7);
    check("t3_rsp_ret", rsp_ret, 0);
    check("t3_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t3_rsp_done", rsp_valid, 0);

    // Response backpressure with a second call queued
    pb = {$urandom, $urandom};
    push_req(64'h41, 8'd1, {$urandom, $urandom}, 1'b0);
    push_req(64'h42, 8'd2, pb, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      check("t4_rsp_valid_hold", rsp_valid, 1);
      check("t4_rsp_id_hold", rsp_call_id, 64'h41);
      check("t4_no_issue", bfm_valid, 0);
      check("t4_count_hold", count, 1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("t4_rsp_released", rsp_valid, 0);
    check("t4_b2b_issue", bfm_valid, 1);
    check("t4_b2b_method", bfm_method, 2);
    check("t4_b2b_params", bfm_params, pb);
    step();
    check("t4_second_rsp", rsp_valid, 1);
    check("t4_second_id", rsp_call_id, 64'h42);
    step();
    rsp_ready = 1'b0;
    check("t4_busy_done", busy, 0);

    // Reset while waiting for an ack with two calls queued
    rsp_ready = 1'b1;
    push_req(64'h51, 8'd1, 64'h1, 1'b1);
    push_req(64'h52, 8'd2, 64'h2, 1'b1);
    push_req(64'h53, 8'd3, 64'h3, 1'b1);
    check("t5_wait_count", count, 2);
    check("t5_wait_no_bfm", bfm_valid, 0);
    check("t5_wait_busy", busy, 1);
    reset_n = 1'b0;
    step();
    check("t5_req_ready", req_ready, 0);
    check("t5_count", count, 0);
    check("t5_bfm_valid", bfm_valid, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_rsp_call_id", rsp_call_id, 0);
    check("t5_bfm_method", bfm_method, 0);
    check("t5_bfm_params", bfm_params, 0);
    reset_n = 1'b1; bfm_ack = 1'b1; bfm_ret = 64'h99;
    step();
    bfm_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t5_no_rsp", rsp_valid, 0);
      check("t5_no_bfm", bfm_valid, 0);
      check("t5_idle", busy, 0);
      step();
    end
    rsp_ready = 1'b0;

    // Never acknowledged blocking call
    bfm_ready = 1'b1;
    push_req(64'h61, 8'd6, 64'h6, 1'b1);
    step();
    step();
    bfm_ready = 1'b0;
`ifdef TBLINK_RPC_INVOKE_SEQ_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      step();
      check("t6_before_tmo", rsp_valid, 0);
    end
    step();
    check("t6_tmo_rsp", rsp_valid, 1);
    check("t6_tmo_err", rsp_err, 1);
    check("t6_tmo_ret", rsp_ret, 0);
    check("t6_tmo_id", rsp_call_id, 64'h61);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t6_busy_done", busy, 0);
`else
    for (int i = 0; i < 30; i++) begin
      step();
      check("t6_no_rsp", rsp_valid, 0);
      check("t6_busy", busy, 1);
    end
`endif
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Randomized traffic against the call/response model
    waiting = 1'b0; wait_cyc = 0; n_push = 0; n_rsp = 0;
    for (int c = 0; c < 1800; c++) begin
      automatic logic drain = (c >= 1500);
      if (bfm_valid) begin
        if (req_q.size() == 0) check("rnd_bfm_without_req", bfm_valid, 0);
        else begin
          check("rnd_bfm_method", bfm_method, req_q[0].m);
          check("rnd_bfm_params", bfm_params, req_q[0].p);
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check("rnd_rsp_without_call", rsp_valid, 0);
        else begin
          check("rnd_rsp_id", rsp_call_id, rsp_q[0].id);
          check("rnd_rsp_ret", rsp_ret, rsp_q[0].ret);
          check("rnd_rsp_err", rsp_err, 0);
        end
      end
      req_valid    = drain ? 1'b0 : 1'($urandom_range(0, 1));
      req_call_id  = {$urandom, $urandom};
      req_method   = 8'($urandom);
      req_params   = {$urandom, $urandom};
      req_blocking = 1'($urandom_range(0, 1));
      bfm_ready    = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      rsp_ready    = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      bfm_ret      = {$urandom, $urandom};
      hs_issue     = bfm_valid && bfm_ready;
      if (waiting)                                     bfm_ack = drain || wait_cyc >= 8 || ($urandom_range(0, 2) == 0);
      else if (hs_issue && req_q.size() != 0 && req_q[0].blk) bfm_ack = 1'($urandom_range(0, 1));
      else if (!bfm_valid)                             bfm_ack = ($urandom_range(0, 3) == 0);
      else                                             bfm_ack = 1'b0;
      if (req_valid && req_ready) begin
        req_q.push_back('{req_call_id, req_method, req_params, req_blocking});
        n_push++;
      end
      if (rsp_valid && rsp_ready && rsp_q.size() != 0) begin
        void'(rsp_q.pop_front());
        n_rsp++;
      end
      if (waiting) begin
        if (bfm_ack) begin
          rsp_q.push_back('{wait_req.id, bfm_ret});
          waiting = 1'b0;
        end else wait_cyc++;
      end else if (hs_issue && req_q.size() != 0) begin
        r = req_q.pop_front();
        if (!r.blk)       rsp_q.push_back('{r.id, 64'h0});
        else if (bfm_ack) rsp_q.push_back('{r.id, bfm_ret});
        else begin
          waiting = 1'b1; wait_req = r; wait_cyc = 0;
        end
      end
      step();
    end
    bfm_ack = 1'b0; bfm_ready = 1'b0; rsp_ready = 1'b0;
    check("rnd_req_q_empty", req_q.size(), 0);
    check("rnd_rsp_q_empty", rsp_q.size(), 0);
    check("rnd_waiting", waiting, 0);
    check("rnd_all_answered", n_rsp, n_push);
    check("rnd_busy_end", busy, 0);
    check("rnd_count_end", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
